// File: rtl/mips_data_memory_pkg.sv
// Shared types for the data memory: dump FSM encodings and the byte-address to word-index helper.
// Pure definitions, no timing or flow-control behaviour of its own.
package mips_data_memory_pkg;

   localparam int DEPTH_LOG2_DEF = 10;
   localparam int DATA_W         = 32;

   typedef enum logic [1:0] {
      DUMP_IDLE = 2'd0,
      DUMP_SEND = 2'd1,
      DUMP_DONE = 2'd2
   } dump_state_t;

   // Word index of a byte address; upper bits beyond l are dropped so addresses wrap.
   function automatic logic [31:0] word_index(input logic [31:0] a, input int unsigned l);
      return (a >> 2) & ((32'd1 << l) - 32'd1);
   endfunction

endpackage

// File: rtl/mips_data_memory_if.sv
// CPU data-memory bus plus the valid/ready dump stream; master is the CPU/host side.
// Carries no state; timing and backpressure are defined by the memory behind the slave modport.
interface mips_data_memory_if;
   import mips_data_memory_pkg::*;

   logic [31:0]       data_memory_a;
   logic              data_memory_we;
   logic [DATA_W-1:0] data_memory_wd;
   logic [DATA_W-1:0] data_memory_rd;
   logic              data_memory_misaligned;
   logic              dump_start;
   logic              dump_valid;
   logic              dump_ready;
   logic [31:0]       dump_addr;
   logic [DATA_W-1:0] dump_data;
   logic              dump_busy;
   logic              dump_done;

   modport master (
      output data_memory_a, data_memory_we, data_memory_wd, dump_start, dump_ready,
      input  data_memory_rd, data_memory_misaligned, dump_valid, dump_addr, dump_data,
             dump_busy, dump_done
   );

   modport slave (
      input  data_memory_a, data_memory_we, data_memory_wd, dump_start, dump_ready,
      output data_memory_rd, data_memory_misaligned, dump_valid, dump_addr, dump_data,
             dump_busy, dump_done
   );

endinterface

// File: rtl/mips_data_memory_dump_engine.sv
// Dump FSM streaming every word in index order; first beat valid one cycle after start, one beat/cycle.
// Holds addr/data while valid && !ready; write-first capture when the CPU writes the word being loaded.
module mem_dump_engine
   import mips_data_memory_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  dump_start,
   input  logic                  dump_ready,
   input  logic [DATA_W-1:0]     rd_word,
   input  logic                  fwd_sel,
   input  logic [DATA_W-1:0]     fwd_data,
   output logic [DEPTH_LOG2-1:0] rd_idx,
   output logic                  dump_valid,
   output logic                  dump_busy,
   output logic                  dump_done,
   output logic [31:0]           dump_addr,
   output logic [DATA_W-1:0]     dump_data
);

   localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;
   localparam logic [DEPTH_LOG2-1:0] ONE_IDX  = DEPTH_LOG2'(1);

   dump_state_t           state, state_nxt;
   logic [DEPTH_LOG2-1:0] idx, idx_nxt;
   logic                  load;

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      load      = 1'b0;
      case (state)
         DUMP_IDLE: begin
            if (dump_start) begin
               state_nxt = DUMP_SEND;
               idx_nxt   = '0;
               load      = 1'b1;
            end
         end
         DUMP_SEND: begin
            if (dump_ready) begin
               if (idx == LAST_IDX) begin
                  state_nxt = DUMP_DONE;
               end else begin
                  idx_nxt = idx + ONE_IDX;
                  load    = 1'b1;
               end
            end
         end
         DUMP_DONE: state_nxt = DUMP_IDLE;
         default:   state_nxt = DUMP_IDLE;
      endcase
   end

   // The array is read at the index being loaded this edge, not the one on display.
   assign rd_idx = idx_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= DUMP_IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dump_valid <= 1'b0;
         dump_busy  <= 1'b0;
         dump_done  <= 1'b0;
         dump_addr  <= '0;
         dump_data  <= '0;
      end else begin
         dump_valid <= (state_nxt == DUMP_SEND);
         dump_busy  <= (state_nxt == DUMP_SEND);
         dump_done  <= (state_nxt == DUMP_DONE);
         if (load) begin
            dump_addr <= 32'({idx_nxt, 2'b00});
            dump_data <= fwd_sel ? fwd_data : rd_word;
         end
      end
   end

endmodule

// File: rtl/mips_data_memory.sv
// Word-addressed data RAM: zero-latency combinational read, posedge write, plus a background dump stream.
// CPU port never stalls; the dump stream obeys dump_ready and is registered.
module mips_data_memory
   import mips_data_memory_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
   input  logic               clk,
   input  logic               reset,
   mips_data_memory_if.slave  bus
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [DEPTH_LOG2-1:0] cpu_idx;
   logic [DEPTH_LOG2-1:0] dump_idx;
   logic                  fwd_sel;

   assign cpu_idx                    = DEPTH_LOG2'(word_index(bus.data_memory_a, DEPTH_LOG2));
   assign bus.data_memory_rd         = mem[cpu_idx];
   assign bus.data_memory_misaligned = |bus.data_memory_a[1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (bus.data_memory_we) begin
         mem[cpu_idx] <= bus.data_memory_wd;
      end
   end

   // A CPU write landing on the word the dump is loading wins over the stale array value.
   assign fwd_sel = bus.data_memory_we && (cpu_idx == dump_idx);

   mem_dump_engine #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_dump (
      .clk        (clk),
      .reset      (reset),
      .dump_start (bus.dump_start),
      .dump_ready (bus.dump_ready),
      .rd_word    (mem[dump_idx]),
      .fwd_sel    (fwd_sel),
      .fwd_data   (bus.data_memory_wd),
      .rd_idx     (dump_idx),
      .dump_valid (bus.dump_valid),
      .dump_busy  (bus.dump_busy),
      .dump_done  (bus.dump_done),
      .dump_addr  (bus.dump_addr),
      .dump_data  (bus.dump_data)
   );

endmodule

// File: tb/tb_mips_data_memory.sv
// Directed bench for mips_data_memory: CPU read/write, wrap, full dump, backpressured dump,
// write-first beat capture and reset in the middle of a dump.
module tb_mips_data_memory;
   import mips_data_memory_pkg::*;

   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mips_data_memory_if bus ();

   mips_data_memory #(.DEPTH_LOG2(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          errors = 0;
   int          checks = 0;
   logic [31:0] model [DEPTH];
   int          e;
   int          cyc;
   logic        r;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [95:0] dump_vec();
      return {29'd0, bus.dump_valid, bus.dump_busy, bus.dump_done, bus.dump_addr, bus.dump_data};
   endfunction

   function automatic logic [95:0] beat_exp(input int b, input logic [31:0] d);
      return {29'd0, 3'b110, 32'(b * 4), d};
   endfunction

   initial begin
      for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
      bus.data_memory_a  = 32'd0;
      bus.data_memory_we = 1'b0;
      bus.data_memory_wd = 32'd0;
      bus.dump_start     = 1'b0;
      bus.dump_ready     = 1'b0;
      reset              = 1'b1;

      // 1: reset state
      @(negedge clk);
      reset = 1'b0;
      #1 check("rst_rd_0", 96'(bus.data_memory_rd), 96'd0);
      bus.data_memory_a = 32'hFFC;
      #1 check("rst_rd_ffc", 96'(bus.data_memory_rd), 96'd0);
      check("rst_dump", dump_vec(), 96'd0);

      // 2: write then read back, same-cycle read sees old value, misaligned flag
      @(negedge clk);
      bus.data_memory_we = 1'b1;
      bus.data_memory_a  = 32'h10;
      bus.data_memory_wd = 32'hDEADBEEF;
      model[4]           = 32'hDEADBEEF;
      #1 check("rd_old_in_write_cycle", 96'(bus.data_memory_rd), 96'd0);
      @(negedge clk);
      bus.data_memory_we = 1'b0;
      #1 check("rd_after_write", 96'(bus.data_memory_rd), 96'(32'hDEADBEEF));
      check("aligned_flag", 96'(bus.data_memory_misaligned), 96'd0);
      bus.data_memory_a = 32'h12;
      #1 check("rd_misaligned_addr", 96'(bus.data_memory_rd), 96'(32'hDEADBEEF));
      check("misaligned_flag", 96'(bus.data_memory_misaligned), 96'd1);

      // 3: address wrap
      @(negedge clk);
      bus.data_memory_we = 1'b1;
      bus.data_memory_a  = 32'h1004;
      bus.data_memory_wd = 32'h1234;
      model[1]           = 32'h1234;
      @(negedge clk);
      bus.data_memory_we = 1'b0;
      bus.data_memory_a  = 32'h4;
      #1 check("rd_wrap", 96'(bus.data_memory_rd), 96'(32'h1234));

      // a few scattered words so the dump carries distinct data
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus.data_memory_we     = 1'b1;
         bus.data_memory_a      = 32'((32'h80 + i * 32'h21) * 4);
         bus.data_memory_wd     = 32'h1000_0000 + 32'(i) * 32'h0101_1111;
         model[32'h80 + i * 32'h21] = bus.data_memory_wd;
      end
      @(negedge clk);
      bus.data_memory_we = 1'b0;
      bus.data_memory_a  = 32'((32'h80 + 3 * 32'h21) * 4);
      #1 check("rd_scatter", 96'(bus.data_memory_rd), 96'(32'h1000_0000 + 32'h0303_3333));

      // 4: full dump with ready held high
      bus.dump_start = 1'b1;
      bus.dump_ready = 1'b1;
      @(negedge clk);
      bus.dump_start = 1'b0;
      for (int b = 0; b < DEPTH; b++) begin
         #1 check("dump_beat", dump_vec(), beat_exp(b, model[b]));
         @(negedge clk);
      end
      #1 check("dump_done_pulse", 96'({bus.dump_valid, bus.dump_busy, bus.dump_done}), 96'(3'b001));
      @(negedge clk);
      #1 check("dump_done_drop", 96'({bus.dump_valid, bus.dump_busy, bus.dump_done}), 96'(3'b000));

      // 5: random backpressure, with a stray dump_start mid-dump
      bus.dump_start = 1'b1;
      bus.dump_ready = 1'b0;
      @(negedge clk);
      bus.dump_start = 1'b0;
      e   = 0;
      cyc = 0;
      while (e < DEPTH && cyc < 6000) begin
         bus.dump_ready = 1'($urandom_range(0, 1));
         bus.dump_start = (cyc == 7);
         r = bus.dump_ready;
         #1 check("bp_beat", dump_vec(), beat_exp(e, model[e]));
         @(negedge clk);
         if (r) e++;
         cyc++;
      end
      bus.dump_start = 1'b0;
      check("bp_all_beats", 96'(e), 96'(DEPTH));
      #1 check("bp_done_pulse", 96'({bus.dump_valid, bus.dump_busy, bus.dump_done}), 96'(3'b001));

      // 6: write-first capture of beat 100, then reset at beat 300
      @(negedge clk);
      bus.dump_start = 1'b1;
      bus.dump_ready = 1'b1;
      @(negedge clk);
      bus.dump_start = 1'b0;
      for (int b = 0; b < 300; b++) begin
         bus.data_memory_we = (b == 99);
         bus.data_memory_a  = 32'h190;
         bus.data_memory_wd = 32'hA5A5A5A5;
         if (b == 99) model[100] = 32'hA5A5A5A5;
         #1 check("fwd_dump_beat", dump_vec(), beat_exp(b, model[b]));
         if (b == 100) check("fwd_beat_data", 96'(bus.dump_data), 96'(32'hA5A5A5A5));
         @(negedge clk);
      end
      #1 check("beat_300", dump_vec(), beat_exp(300, model[300]));
      reset              = 1'b1;
      bus.data_memory_we = 1'b1;
      bus.data_memory_a  = 32'h20;
      bus.data_memory_wd = 32'hFFFF;
      @(negedge clk);
      reset              = 1'b0;
      bus.data_memory_we = 1'b0;
      #1 check("mid_dump_reset", dump_vec(), 96'd0);
      check("reset_write_dropped", 96'(bus.data_memory_rd), 96'd0);
      bus.data_memory_a = 32'h10;
      #1 check("reset_clears_mem", 96'(bus.data_memory_rd), 96'd0);
      bus.data_memory_a = 32'h190;
      #1 check("reset_clears_fwd_word", 96'(bus.data_memory_rd), 96'd0);
      @(negedge clk);
      #1 check("idle_after_reset", dump_vec(), 96'd0);
      bus.dump_start = 1'b1;
      bus.dump_ready = 1'b0;
      @(negedge clk);
      bus.dump_start = 1'b0;
      #1 check("restart_after_reset", dump_vec(), beat_exp(0, 32'd0));
      @(negedge clk);
      #1 check("stall_hold", dump_vec(), beat_exp(0, 32'd0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
